// File: rtl/iter_counter_pkg.sv
// iter_counter_pkg: shared state encoding and default load for the iteration controllers
package iter_counter_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int ITER_DEFAULT_LOAD = 32;
endpackage

// File: rtl/iter_counter.sv
// iter_counter: loadable up/down iteration counter with busy flag and one-cycle terminal pulse
module iter_counter
    import iter_counter_pkg::*;
#(
    parameter int WIDTH        = 6,
    parameter int DEFAULT_LOAD = ITER_DEFAULT_LOAD
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadVal,
    input  logic             UseDefault,
    input  logic             Mode,
    input  logic             En,
    output logic [WIDTH-1:0] Count,
    output logic             Busy,
    output logic             K
);
    state_t           state, state_nxt;
    logic [WIDTH-1:0] n_q, n_sel, term, step, count_nxt;
    logic             mode_q;
    assign n_sel = UseDefault ? WIDTH'(DEFAULT_LOAD) : LoadVal;
    assign term  = mode_q ? n_q : '0;
    assign step  = mode_q ? Count + 1'b1 : Count - 1'b1;
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state  <= IDLE;
            Count  <= '0;
            n_q    <= '0;
            mode_q <= 1'b0;
            Busy   <= 1'b0;
            K      <= 1'b0;
        end else begin
            state <= state_nxt;
            Count <= count_nxt;
            Busy  <= state_nxt == RUN;
            K     <= state_nxt == DONE;
            if (Load) begin
                n_q    <= n_sel;
                mode_q <= Mode;
            end
        end
    end
    // Load wins over everything; a zero-length run completes on the load edge itself
    always_comb begin
        state_nxt = state;
        if (Load)
            state_nxt = (n_sel == '0) ? DONE : RUN;
        else if (state == RUN)
            state_nxt = (En && step == term) ? DONE : RUN;
        else if (state == DONE)
            state_nxt = IDLE;
    end
    always_comb begin
        count_nxt = Count;
        if (Load)
            count_nxt = Mode ? '0 : n_sel;
        else if (state == RUN && En)
            count_nxt = step;
    end
endmodule

// File: tb/tb_iter_counter.sv
// tb_iter_counter: table vectors, directed corner sequences and random stimulus vs a run-progress model
module tb_iter_counter;
    import iter_counter_pkg::*;
    localparam int W = 6;
    typedef struct {int ld, lv, ud, md, en, cnt, busy, k;} vec_t;
    logic         Clk = 1'b0, Reset_n = 1'b0, Load = 1'b0, UseDefault = 1'b0, Mode = 1'b0, En = 1'b0;
    logic [W-1:0] LoadVal = '0;
    logic [W-1:0] Count;
    logic         Busy, K;
    int vectors = 0, miscompares = 0;
    int m_n = 0, m_steps = 0;
    bit m_mode = 0, m_busy = 0, m_k = 0;
    vec_t tbl[16];
    iter_counter #(.WIDTH(W)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Load(Load), .LoadVal(LoadVal), .UseDefault(UseDefault),
        .Mode(Mode), .En(En), .Count(Count), .Busy(Busy), .K(K)
    );
    always #5 Clk = ~Clk;
    task automatic expect_eq(input string name, input logic [31:0] act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
    // The model tracks how many enabled steps of the current run have elapsed
    function automatic int model_count();
        return m_mode ? m_steps : m_n - m_steps;
    endfunction
    task automatic model_reset();
        m_n = 0; m_steps = 0; m_mode = 0; m_busy = 0; m_k = 0;
    endtask
    task automatic model_edge(input bit ld, input int lv, input bit ud, input bit md, input bit en);
        if (ld) begin
            m_n = ud ? ITER_DEFAULT_LOAD % (1 << W) : lv;
            m_mode = md; m_steps = 0;
            m_busy = m_n != 0; m_k = m_n == 0;
        end else if (m_busy) begin
            if (en) m_steps++;
            if (m_steps == m_n) begin m_busy = 0; m_k = 1; end
        end else m_k = 0;
    endtask
    task automatic check_model(input string tag);
        expect_eq({tag, " count"}, 32'(Count), model_count());
        expect_eq({tag, " busy"}, 32'(Busy), int'(m_busy));
        expect_eq({tag, " k"}, 32'(K), int'(m_k));
    endtask
    task automatic cycle(input bit ld, input int lv, input bit ud, input bit md, input bit en, input string tag);
        Load = ld; LoadVal = W'(lv); UseDefault = ud; Mode = md; En = en;
        @(posedge Clk);
        model_edge(ld, lv, ud, md, en);
        #1;
        check_model(tag);
    endtask
    task automatic run(input int edges, input int off_from, input int off_len,
                       output int k_at, output int busy_n, output int k_n);
        k_at = -1; busy_n = 0; k_n = 0;
        for (int i = 1; i <= edges; i++) begin
            cycle(0, 0, 0, 0, !(i >= off_from && i < off_from + off_len), "run");
            if (Busy) busy_n++;
            if (K) begin
                k_n++;
                if (k_at < 0) k_at = i;
            end
        end
    endtask
    task automatic do_reset(input string tag);
        #3;
        Reset_n = 1'b0; Load = 1'b0;
        model_reset();
        #1;
        expect_eq({tag, " async count"}, 32'(Count), 0);
        expect_eq({tag, " async busy"}, 32'(Busy), 0);
        expect_eq({tag, " async k"}, 32'(K), 0);
        @(posedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
    endtask
    initial begin
        int k_at, busy_n, k_n, b0;
        tbl = '{
            '{1, 3, 0, 0, 1,  3, 1, 0}, '{0, 0, 0, 0, 1,  2, 1, 0}, '{0, 0, 0, 0, 0,  2, 1, 0},
            '{0, 0, 0, 0, 1,  1, 1, 0}, '{0, 0, 0, 0, 1,  0, 0, 1}, '{0, 0, 0, 0, 1,  0, 0, 0},
            '{1, 0, 0, 0, 1,  0, 0, 1}, '{0, 0, 0, 0, 1,  0, 0, 0}, '{1, 2, 0, 1, 1,  0, 1, 0},
            '{0, 0, 0, 0, 1,  1, 1, 0}, '{1, 1, 0, 0, 1,  1, 1, 0}, '{0, 0, 0, 0, 1,  0, 0, 1},
            '{0, 0, 0, 0, 1,  0, 0, 0}, '{1, 5, 1, 0, 1, 32, 1, 0}, '{0, 0, 0, 0, 1, 31, 1, 0},
            '{1, 7, 0, 1, 0,  0, 1, 0}
        };
        #12;
        expect_eq("reset count", 32'(Count), 0);
        expect_eq("reset busy", 32'(Busy), 0);
        expect_eq("reset k", 32'(K), 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        foreach (tbl[i]) begin
            cycle(tbl[i].ld != 0, tbl[i].lv, tbl[i].ud != 0, tbl[i].md != 0, tbl[i].en != 0, $sformatf("tbl%0d", i));
            expect_eq($sformatf("tbl%0d count", i), 32'(Count), tbl[i].cnt);
            expect_eq($sformatf("tbl%0d busy", i), 32'(Busy), tbl[i].busy);
            expect_eq($sformatf("tbl%0d k", i), 32'(K), tbl[i].k);
        end
        cycle(1, 9, 1, 0, 1, "dflt load");
        b0 = int'(Busy);
        run(36, 0, 0, k_at, busy_n, k_n);
        expect_eq("dflt k edge", 32'(k_at), 32);
        expect_eq("dflt busy cycles", 32'(busy_n + b0), 32);
        expect_eq("dflt k cycles", 32'(k_n), 1);
        for (int i = 0; i < 5; i++) begin
            cycle(1, 10, 0, 1, 1, "held load");
            expect_eq("held load count", 32'(Count), 0);
        end
        run(14, 0, 0, k_at, busy_n, k_n);
        expect_eq("held k edge", 32'(k_at), 10);
        expect_eq("held final count", 32'(Count), 10);
        cycle(1, 8, 0, 0, 1, "freeze load");
        run(14, 4, 3, k_at, busy_n, k_n);
        expect_eq("freeze k edge", 32'(k_at), 11);
        cycle(1, 0, 0, 0, 1, "zero load");
        b0 = int'(Busy);
        expect_eq("zero k at load", 32'(K), 1);
        run(3, 0, 0, k_at, busy_n, k_n);
        expect_eq("zero busy", 32'(busy_n + b0), 0);
        expect_eq("zero k cycles", 32'(k_n), 0);
        cycle(1, 16, 0, 0, 1, "abort load");
        run(11, 0, 0, k_at, busy_n, k_n);
        expect_eq("abort count before reset", 32'(Count), 5);
        do_reset("abort");
        run(3, 0, 0, k_at, busy_n, k_n);
        expect_eq("abort no k", 32'(k_n), 0);
        cycle(1, 4, 0, 0, 1, "post reset load");
        run(6, 0, 0, k_at, busy_n, k_n);
        expect_eq("post reset k edge", 32'(k_at), 4);
        cycle(1, 6, 0, 0, 1, "restart load");
        run(5, 0, 0, k_at, busy_n, k_n);
        expect_eq("restart count", 32'(Count), 1);
        cycle(1, 3, 0, 0, 1, "restart reload");
        expect_eq("restart no k", 32'(K), 0);
        run(5, 0, 0, k_at, busy_n, k_n);
        expect_eq("restart k edge", 32'(k_at), 3);
        expect_eq("restart k cycles", 32'(k_n), 1);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset("rnd");
            else cycle($urandom_range(0, 7) == 0, int'($urandom_range(0, 12)), $urandom_range(0, 15) == 0,
                       1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, "rnd");
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/iter_counter.md
ITER_COUNTER -- requirements
Module: iter_counter

Interface
REQ-001 Parameter WIDTH, default 6, bit width of the count and load value.
REQ-002 Parameter DEFAULT_LOAD, default 32, value used when UseDefault is high at load.
REQ-003 Clk  input  1  single clock; all state changes on rising edge.
REQ-004 Reset_n  input  1  asynchronous active-low reset, asserts immediately, released synchronously to Clk by the system.
REQ-005 Load  input  1  start/restart request, sampled on every rising Clk edge.
REQ-006 LoadVal  input  WIDTH  iteration count N, sampled on the edge where Load is high.
REQ-007 UseDefault  input  1  when high at load, N = DEFAULT_LOAD (truncated to WIDTH) and LoadVal is ignored.
REQ-008 Mode  input  1  0 = count down from N to 0, 1 = count up from 0 to N; latched at load.
REQ-009 En  input  1  count enable; low freezes Count in RUN.
REQ-010 Count  output  WIDTH  current count value, registered.
REQ-011 Busy  output  1  high while in RUN state, registered.
REQ-012 K  output  1  terminal pulse, registered, high for exactly one cycle per completed run.

Function
REQ-013 The block SHALL implement three states: IDLE, RUN, DONE.
REQ-014 Load high at an edge in any state SHALL set Count to N (Mode=0) or 0 (Mode=1), latch N and Mode, clear K, and enter RUN; Load has priority over En and completion.
REQ-015 Load held for several edges SHALL reload on each edge; counting starts on the first edge after Load falls.
REQ-016 In RUN with En high and Load low, Count SHALL decrement (Mode=0) or increment (Mode=1) by one per edge.
REQ-017 In RUN with En low, Count and state SHALL hold.
REQ-018 The edge that makes Count equal the terminal value (0 down, N up) SHALL move the state to DONE; K is high for the following cycle only.
REQ-019 Load with N=0 SHALL go directly to DONE; K pulses one cycle after the load edge.
REQ-020 DONE SHALL return to IDLE on the next edge unless Load is high; Count holds its terminal value in DONE and IDLE.
REQ-021 With En constant high, K SHALL rise N edges after the last Load edge (N>=1); Busy is high for exactly N cycles.
REQ-022 Count SHALL never wrap: no decrement below 0 and no increment beyond N.
REQ-023 Load arriving in the same edge as completion SHALL restart (no K pulse for the interrupted run).
REQ-024 Busy and K SHALL never be high simultaneously.

Reset
REQ-025 Reset_n low SHALL immediately force state IDLE, Count=0, Busy=0, K=0, latched N=0, latched Mode=0.
REQ-026 Reset mid-run SHALL abort the run with no K pulse; normal operation resumes on the first Load after release.

Structure
REQ-027 State encoding (IDLE/RUN/DONE) and DEFAULT_LOAD default SHALL live in shared package iter_counter_pkg, for reuse by the multiplier and divider controllers.
REQ-028 The block SHALL be a single module with no sub-modules; next-state logic and registers in one file.

Verification
REQ-029 Reset, Load 1 cycle, UseDefault=1, Mode=0, En=1 -> Count 32,31..0, Busy 32 cycles, K one-cycle pulse 32 edges after load, then IDLE.
REQ-030 Load held 5 cycles with LoadVal=10, Mode=1 -> Count stays 0 during Load, then 1..10, K 10 edges after Load falls.
REQ-031 LoadVal=8, Mode=0, En low for 3 cycles mid-run -> Count frozen, K delayed by exactly 3 cycles (11 edges after load).
REQ-032 LoadVal=0 -> no RUN, Busy stays 0, K pulses one cycle after load edge.
REQ-033 Reset_n low at Count=5 of a 16-cycle run -> outputs immediately 0, no K; new Load of 4 -> K after 4 edges.
REQ-034 Load asserted on completion edge of LoadVal=6 run with LoadVal=3 -> no K for first run, K 3 edges later.
